alu_issue_arbiter: RTL
======================

// Module: alu_issue_arbiter
// PURPOSE
//  Shares the single 16-bit ALU (ADD/SUB/XOR/RED/SLL/SRA/ROR/PADDSB/LW/SW addr) between two requesters
//  (req0 = execute stage, req1 = address/auxiliary path). Arbitrates round-robin, registers operands,
//  captures ALU result, returns it via valid/ready response, and owns the architectural Z/V/N flag register.
// PARAMETERS
//  DW   16  datapath width of operands, result, ALU ports
//  OPW  4   opcode width (ALU Inst encoding)
// PORTS
//  clk          in   1    system clock, all state on rising edge
//  rst_n        in   1    synchronous active-low reset
//  req0_valid   in   1    requester 0 has an op
//  req0_ready   out  1    requester 0 accepted this cycle (valid&ready = handshake)
//  req0_op      in   OPW  requester 0 opcode
//  req0_a/b     in   DW   requester 0 operands
//  req1_*       --   --   identical set for requester 1
//  alu_inst     out  OPW  to ALU Inst
//  alu_in1/in2  out  DW   to ALU operands
//  alu_out      in   DW   ALU result (combinational from alu_* outputs)
//  alu_z/v/n    in   1    ALU flag outputs
//  rsp_valid    out  1    response available
//  rsp_ready    in   1    consumer takes response
//  rsp_id       out  1    which requester owns response
//  rsp_data     out  DW   captured result
//  rsp_err      out  1    op was illegal (opcode >= 4'b1010)
//  flag_z/v/n   out  1    architectural flags
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, rr_last=1 (req0 wins first tie), all outputs 0, flags 0.
//   Reset mid-operation discards issued op and pending response; no flag update that cycle.
//  FSM IDLE -> EXEC -> RESP.
//   IDLE: readyX=1 for granted requester only, combinationally from valids; on handshake latch
//    op/a/b/id into issue regs, rr_last<=id, go EXEC. No valid: stay.
//   EXEC (1 cycle): alu_inst/in1/in2 driven from issue regs (held at 0 in other states);
//    capture alu_out->rsp_data, update flags, go RESP.
//   RESP: rsp_valid=1; data/id/err stable until rsp_ready. On rsp_ready: if any req valid,
//    grant+accept same cycle (ready asserted) and go EXEC; else go IDLE. No ready: hold.
//  Latency: handshake at cycle N -> rsp_valid at N+2. Peak throughput 1 op / 2 cycles.
//  Arbitration: one valid -> it wins. Both valid -> requester != rr_last wins. Never both readies.
//  Flag update (in EXEC only): ADD 0000, SUB 0001 -> Z,V,N; XOR 0010, SLL 0100, SRA 0101,
//   ROR 0110 -> Z only; RED 0011, PADDSB 0111, LW 1000, SW 1001 -> none.
//  Illegal op (1010-1111): ALU not driven (inst/in1/in2=0), rsp_data=0, rsp_err=1, no flag update.
//  Requester must hold op/a/b stable while valid&!ready; arbiter samples only at handshake.
// STRUCTURE
//  Shared package: opcode localparams (OP_ADD..OP_SW), OP_ILLEGAL_MIN=4'b1010, FSM state encoding,
//   flag-mask function opcode -> {upd_z,upd_v,upd_n}.
//  Sub-module: rr_arbiter2 (2 valids + rr_last -> one-hot grant, combinational).
//  Top: FSM, issue regs, response regs, flag regs.
// TESTING
//  1 req0 ADD a=0x7FFF b=0x0001 -> rsp_id=0 at +2 cycles, rsp_data=0x7FFF (saturated), V=1 N=0 Z=0.
//  2 req0,req1 valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; one op per 2 cycles.
//  3 XOR a=b=0x1234 after SUB set V=1 -> Z=1, V and N unchanged from SUB.
//  4 PADDSB 0x1111+0x2222 -> rsp_data=0x3333, flags unchanged; opcode 1100 -> rsp_err=1, data=0.
//  5 rsp_ready=0 for 5 cycles in RESP -> rsp_valid/data stable, req readies 0, no new accept.
//  6 rst_n=0 during EXEC -> next cycle all outputs 0, flags 0, first tie grants req0.

Source files
------------

// File: rtl/alu_issue_arbiter_pkg.sv
// alu_issue_arbiter_pkg: opcodes, FSM states and flag-update mask for the ALU issue arbiter
package alu_issue_arbiter_pkg;
    localparam int DW = 16;
    localparam int OPW = 4;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_RED = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW = 4'b1000;
    localparam logic [3:0] OP_SW = 4'b1001;
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'b1010;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
    function automatic logic [2:0] flag_mask(input logic [3:0] op);
        return (op == OP_ADD || op == OP_SUB) ? 3'b111 :
               (op == OP_XOR || op == OP_SLL || op == OP_SRA || op == OP_ROR) ? 3'b100 : 3'b000;
    endfunction
endpackage

// File: rtl/alu_issue_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, the requester that did not win last time wins a tie
module rr_arbiter2 (
    input  logic       v0,
    input  logic       v1,
    input  logic       rr_last,
    output logic [1:0] grant
);
    assign grant = {v1 & (~v0 | ~rr_last), v0 & (~v1 | rr_last)};
endmodule

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: shares one ALU between two requesters, returns results and owns the Z/V/N flags
module alu_issue_arbiter
    import alu_issue_arbiter_pkg::*;
#(
    parameter int DW = 16,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    output logic [OPW-1:0] alu_inst,
    output logic [DW-1:0]  alu_in1,
    output logic [DW-1:0]  alu_in2,
    input  logic [DW-1:0]  alu_out,
    input  logic           alu_z,
    input  logic           alu_v,
    input  logic           alu_n,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [DW-1:0]  rsp_data,
    output logic           rsp_err,
    output logic           flag_z,
    output logic           flag_v,
    output logic           flag_n
);
    state_t         state, state_n;
    logic [OPW-1:0] iss_op;
    logic [DW-1:0]  iss_a, iss_b;
    logic           iss_id, rr_last;
    logic [1:0]     grant;
    logic           accept, hs, exec, illegal, drive;
    logic [2:0]     upd;

    rr_arbiter2 u_arb (.v0(req0_valid), .v1(req1_valid), .rr_last(rr_last), .grant(grant));

    assign accept = state == ST_IDLE || (state == ST_RESP && rsp_ready);
    assign hs = accept && grant != 2'b00;
    assign req0_ready = accept & grant[0];
    assign req1_ready = accept & grant[1];
    assign exec = state == ST_EXEC;
    assign illegal = iss_op >= OP_ILLEGAL_MIN;
    assign drive = exec && !illegal;
    assign alu_inst = drive ? iss_op : '0;
    assign alu_in1 = drive ? iss_a : '0;
    assign alu_in2 = drive ? iss_b : '0;
    assign rsp_valid = state == ST_RESP;
    assign upd = illegal ? 3'b000 : flag_mask(iss_op);

    // next state: accept goes to EXEC, EXEC always lands in RESP, RESP holds until consumed
    always_comb begin
        state_n = hs ? ST_EXEC :
                  exec ? ST_RESP :
                  (state == ST_RESP && !rsp_ready) ? ST_RESP : ST_IDLE;
    end

    // state, issue capture at handshake, result and flag capture in EXEC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            rr_last <= 1'b1;
            iss_op <= '0;
            iss_a <= '0;
            iss_b <= '0;
            iss_id <= 1'b0;
            rsp_id <= 1'b0;
            rsp_data <= '0;
            rsp_err <= 1'b0;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            state <= state_n;
            if (hs) begin
                iss_op <= grant[1] ? req1_op : req0_op;
                iss_a <= grant[1] ? req1_a : req0_a;
                iss_b <= grant[1] ? req1_b : req0_b;
                iss_id <= grant[1];
                rr_last <= grant[1];
            end
            if (exec) begin
                rsp_id <= iss_id;
                rsp_data <= illegal ? '0 : alu_out;
                rsp_err <= illegal;
                flag_z <= upd[2] ? alu_z : flag_z;
                flag_v <= upd[1] ? alu_v : flag_v;
                flag_n <= upd[0] ? alu_n : flag_n;
            end
        end
    end
endmodule
